simd_mac_unit: RTL and testbench

Parametrised, sequential successor to the fixed 4-lane multiplier: a signed SIMD multiply / multiply-accumulate unit with per-lane accumulators, valid/ready handshakes and per-lane overflow flags. One shared multiplier processes one lane per cycle, trading latency for area. It sits in the AI-acceleration datapath beside the core and is fed packed operand vectors by the issue logic.

---
 rtl/simd_mac_unit_if.sv | 26 ++
 rtl/simd_mac_unit.sv | 121 ++++++++++++
 tb/tb_simd_mac_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/simd_mac_unit_if.sv
// Handshake and operand/result bundle for simd_mac_unit.
// The master side issues packed operand vectors and consumes results.
interface simd_mac_unit_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32
);
  logic                      in_valid;
  logic                      in_ready;
  logic [1:0]                mode;
  logic [LANES*DATA_W-1:0]   operand_a;
  logic [LANES*DATA_W-1:0]   operand_b;
  logic                      out_valid;
  logic                      out_ready;
  logic [LANES*DATA_W-1:0]   result;
  logic [LANES-1:0]          overflow;

  modport master (
    output in_valid, mode, operand_a, operand_b, out_ready,
    input  in_ready, out_valid, result, overflow
  );

  modport slave (
    input  in_valid, mode, operand_a, operand_b, out_ready,
    output in_ready, out_valid, result, overflow
  );
endinterface

// File: rtl/simd_mac_unit.sv
// Sequential signed SIMD multiply / multiply-accumulate, one shared multiplier, one lane per cycle.
// Optional build macro SATURATE_EN clamps result lanes instead of truncating them.
module simd_mac_unit #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ACC_W  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  simd_mac_unit_if.slave bus
);

  localparam int unsigned     CNT_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LANES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL, OP_MAC, OP_CLR} op_t;

  state_t state, state_next;
  op_t    op_in, op_q;

  logic [CNT_W-1:0]        cnt;
  logic [LANES*DATA_W-1:0] a_q, b_q, result_q;
  logic [LANES-1:0]        ovf_q;
  logic [ACC_W-1:0]        acc [LANES];

  logic                         accept;
  logic                         in_ready_c, out_valid_c;
  logic signed [DATA_W-1:0]     lane_a, lane_b;
  logic signed [2*DATA_W-1:0]   product;
  logic signed [ACC_W-1:0]      prod_ext, acc_sum, lane_val;
  logic [ACC_W-DATA_W:0]        upper;
  logic                         lane_ovf;
  logic [DATA_W-1:0]            lane_res;

  always_comb begin
    op_in = OP_MUL;
    unique case (bus.mode)
      2'b01:   op_in = OP_MAC;
      2'b10:   op_in = OP_CLR;
      default: op_in = OP_MUL;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // CLR takes one BUSY cycle that writes nothing, so its result appears one cycle after acceptance.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (accept) state_next = BUSY;
      BUSY: if (op_q == OP_CLR || cnt == LAST) state_next = DONE;
      DONE: if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready_c  = (state == IDLE);
    out_valid_c = (state == DONE);
    accept      = bus.in_valid && in_ready_c;
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.overflow  = ovf_q;

  always_comb begin
    lane_a   = a_q[int'(cnt)*DATA_W +: DATA_W];
    lane_b   = b_q[int'(cnt)*DATA_W +: DATA_W];
    product  = lane_a * lane_b;
    prod_ext = ACC_W'(product);
    acc_sum  = acc[cnt] + prod_ext;
    lane_val = (op_q == OP_MAC) ? acc_sum : prod_ext;
    // Representable in DATA_W signed iff the bits from the DATA_W sign bit upward all agree.
    upper    = lane_val[ACC_W-1:DATA_W-1];
    lane_ovf = !((&upper) || !(|upper));
`ifdef SATURATE_EN
    if (lane_ovf)
      lane_res = lane_val[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
    else
      lane_res = lane_val[DATA_W-1:0];
`else
    lane_res = lane_val[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_MUL;
      cnt      <= '0;
      result_q <= '0;
      ovf_q    <= '0;
      for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
    end else if (accept) begin
      a_q  <= bus.operand_a;
      b_q  <= bus.operand_b;
      op_q <= op_in;
      cnt  <= '0;
      if (op_in == OP_CLR) begin
        result_q <= '0;
        ovf_q    <= '0;
        for (int unsigned i = 0; i < LANES; i++) acc[i] <= '0;
      end
    end else if (state == BUSY && op_q != OP_CLR) begin
      result_q[int'(cnt)*DATA_W +: DATA_W] <= lane_res;
      ovf_q[cnt] <= lane_ovf;
      if (op_q == OP_MAC) acc[cnt] <= acc_sum;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_simd_mac_unit.sv
// Directed-vector bench for simd_mac_unit (default 4 x 32-bit lanes, 64-bit accumulators).
module tb_simd_mac_unit;

  localparam logic [1:0] M_MUL = 2'b00, M_MAC = 2'b01, M_CLR = 2'b10, M_ALT = 2'b11;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  simd_mac_unit_if #(.LANES(4), .DATA_W(32)) bus ();

  simd_mac_unit #(.LANES(4), .DATA_W(32), .ACC_W(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]   mode;
    logic [127:0] a;
    logic [127:0] b;
    logic [127:0] r;
    logic [3:0]   ovf;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [127:0] pk(logic [31:0] l0, logic [31:0] l1,
                                      logic [31:0] l2, logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [31:0] sat_sel(logic [31:0] trunc_v, logic [31:0] sat_v);
`ifdef SATURATE_EN
    return sat_v;
`else
    return trunc_v;
`endif
  endfunction

  task automatic check(string name, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic issue(logic [1:0] m, logic [127:0] a, logic [127:0] b);
    @(negedge clk);
    bus.mode      = m;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  // out_ready is held high from before acceptance, so the handshake lands on the first DONE edge.
  task automatic run_vec(vec_t v, string id);
    int lat;
    bus.out_ready = 1'b1;
    check({id, " in_ready before"}, bus.in_ready, 1);
    issue(v.mode, v.a, v.b);
    wait_valid(lat);
    check({id, " latency"}, lat, v.lat);
    check({id, " result"}, bus.result, v.r);
    check({id, " overflow"}, bus.overflow, v.ovf);
    @(posedge clk);
    #1;
    check({id, " out_valid after hs"}, bus.out_valid, 0);
    check({id, " in_ready after hs"}, bus.in_ready, 1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    vec_t v;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.mode      = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;

    #3 rst_n = 1'b0;
    #1;
    check("reset out_valid", bus.out_valid, 0);
    check("reset result", bus.result, 0);
    check("reset overflow", bus.overflow, 0);
    check("reset in_ready", bus.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;

    vecs[0] = '{M_MUL, pk(32'd3, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'd5),
                       pk(32'd4, 32'd7, 32'd2, 32'hFFFF_FFFF),
                       pk(32'd12, 32'hFFFF_FFF2, sat_sel(32'hFFFF_FFFE, 32'h7FFF_FFFF), 32'hFFFF_FFFB),
                       4'b0100, 4};
    vecs[1] = '{M_CLR, pk(32'd9, 32'd9, 32'd9, 32'd9), pk(32'd9, 32'd9, 32'd9, 32'd9),
                       '0, 4'b0000, 1};
    vecs[2] = '{M_MAC, pk(32'd10, 32'd10, 32'd10, 32'd10), pk(32'd10, 32'd10, 32'd10, 32'd10),
                       pk(32'd100, 32'd100, 32'd100, 32'd100), 4'b0000, 4};
    vecs[3] = '{M_MAC, pk(32'd10, 32'd10, 32'd10, 32'd10), pk(32'd10, 32'd10, 32'd10, 32'd10),
                       pk(32'd200, 32'd200, 32'd200, 32'd200), 4'b0000, 4};
    vecs[4] = '{M_MUL, pk(32'hFFFF_FFFD, 32'hFFFF_FFFC, 32'h8000_0000, 32'd0),
                       pk(32'hFFFF_FFFB, 32'd6, 32'h8000_0000, 32'd12345),
                       pk(32'd15, 32'hFFFF_FFE8, sat_sel(32'h0, 32'h7FFF_FFFF), 32'd0),
                       4'b0100, 4};
    vecs[5] = '{M_MAC, pk(32'd1, 32'hFFFF_FFFF, 32'd0, 32'd2),
                       pk(32'd1, 32'd1, 32'd0, 32'hFFFF_FFFD),
                       pk(32'd201, 32'd199, 32'd200, 32'd194), 4'b0000, 4};
    vecs[6] = '{M_CLR, '0, '0, '0, 4'b0000, 1};
    vecs[7] = '{M_MAC, pk(32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000),
                       pk(32'd2, 32'd1, 32'd1, 32'd1),
                       pk(sat_sel(32'h0, 32'h8000_0000), 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000),
                       4'b0001, 4};
    vecs[8] = '{M_ALT, pk(32'd6, 32'd6, 32'd6, 32'd6), pk(32'd7, 32'd7, 32'd7, 32'd7),
                       pk(32'd42, 32'd42, 32'd42, 32'd42), 4'b0000, 4};
    vecs[9] = '{M_CLR, '0, '0, '0, 4'b0000, 1};

    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held in DONE, new requests ignored.
    bus.out_ready = 1'b0;
    issue(M_MUL, vecs[0].a, vecs[0].b);
    wait_valid(lat);
    check("bp latency", lat, 4);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.mode      = M_MAC;
      bus.operand_a = pk(32'd1, 32'd1, 32'd1, 32'd1);
      bus.operand_b = pk(32'd1, 32'd1, 32'd1, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("bp%0d out_valid", c), bus.out_valid, 1);
      check($sformatf("bp%0d in_ready", c), bus.in_ready, 0);
      check($sformatf("bp%0d result", c), bus.result, vecs[0].r);
      check($sformatf("bp%0d overflow", c), bus.overflow, 4'b0100);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release in_ready", bus.in_ready, 1);
    check("bp release out_valid", bus.out_valid, 0);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("bp no queued in_ready", bus.in_ready, 1);
    check("bp no queued out_valid", bus.out_valid, 0);

    // Accumulator grows past DATA_W on every pass.
    v = '{M_MAC, pk(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000),
                 pk(32'd4, 32'd4, 32'd4, 32'd4),
                 pk(sat_sel(32'h0, 32'h7FFF_FFFF), sat_sel(32'h0, 32'h7FFF_FFFF),
                    sat_sel(32'h0, 32'h7FFF_FFFF), sat_sel(32'h0, 32'h7FFF_FFFF)),
                 4'b1111, 4};
    for (int k = 0; k < 4; k++) run_vec(v, $sformatf("big%0d", k));

    // Reset while lane 2 is being processed.
    bus.out_ready = 1'b0;
    issue(M_MAC, pk(32'd5, 32'd5, 32'd5, 32'd5), pk(32'd5, 32'd5, 32'd5, 32'd5));
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst out_valid", bus.out_valid, 0);
    check("midrst result", bus.result, 0);
    check("midrst overflow", bus.overflow, 0);
    check("midrst in_ready", bus.in_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    v = '{M_MAC, pk(32'd1, 32'd1, 32'd1, 32'd1), pk(32'd1, 32'd1, 32'd1, 32'd1),
                 pk(32'd1, 32'd1, 32'd1, 32'd1), 4'b0000, 4};
    run_vec(v, "post-reset mac");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
